// File: rtl/mem_access_ctrl_if.sv
// Data-memory req/ack port between the MEM-stage controller (master) and the memory (slave).
interface mem_access_ctrl_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic        dmem_err;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      input  dmem_ack, dmem_err, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
      output dmem_ack, dmem_err, dmem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: turns the EX/MEM access into a req/ack transaction, stalls the
// pipeline until it completes and defers branch flushes raised while stalled.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               mem_nop,
   input  logic               exmem_mem_r,
   input  logic               exmem_mem_w,
   input  logic [3:0]         mem_byte_w_en_out,
   input  logic [31:0]        exmem_alu_res,
   input  logic [31:0]        exmem_aligned_rt_data,
   input  logic               flush_req,
   mem_access_ctrl_if.master  dmem,
   output logic               cu_stall,
   output logic               cu_flush,
   output logic [31:0]        load_data,
   output logic               load_valid,
   output logic               bus_err,
   output logic               timeout
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYC - 1);

   state_e           state;
   logic             flush_pend;
   logic [CNT_W-1:0] cnt;
   logic             access;

   assign access = !mem_nop && (exmem_mem_r || exmem_mem_w);

   // Gated by reset so nothing is frozen or flushed while the core is held in reset.
   assign cu_stall = reset_n && ((state == StIdle && access) || state == StReq);
   assign cu_flush = reset_n && !cu_stall && (flush_req || flush_pend);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= StIdle;
         flush_pend      <= 1'b0;
         cnt             <= '0;
         dmem.dmem_req   <= 1'b0;
         dmem.dmem_we    <= 1'b0;
         dmem.dmem_addr  <= '0;
         dmem.dmem_be    <= '0;
         dmem.dmem_wdata <= '0;
         load_data       <= '0;
         load_valid      <= 1'b0;
         bus_err         <= 1'b0;
         timeout         <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         bus_err    <= 1'b0;
         timeout    <= 1'b0;

         // Pipeline registers ignore cu_flush while stalled, so hold the flush until release.
         if (cu_stall) begin
            if (flush_req) flush_pend <= 1'b1;
         end else begin
            flush_pend <= 1'b0;
         end

         unique case (state)
            StIdle: begin
               if (access) begin
                  state           <= StReq;
                  dmem.dmem_req   <= 1'b1;
                  dmem.dmem_we    <= exmem_mem_w;
                  dmem.dmem_addr  <= {exmem_alu_res[31:2], 2'b00};
                  dmem.dmem_be    <= exmem_mem_w ? mem_byte_w_en_out : 4'hF;
                  dmem.dmem_wdata <= exmem_aligned_rt_data;
                  cnt             <= '0;
               end
            end
            StReq: begin
               if (dmem.dmem_ack) begin
                  state         <= StDone;
                  dmem.dmem_req <= 1'b0;
                  bus_err       <= dmem.dmem_err;
                  if (!dmem.dmem_we) begin
                     load_data  <= dmem.dmem_rdata;
                     load_valid <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
                  if (cnt == CntLast) begin
                     state         <= StDone;
                     dmem.dmem_req <= 1'b0;
                     timeout       <= 1'b1;
                     load_data     <= '0;
                     load_valid    <= !dmem.dmem_we;
                  end
               end
            end
            StDone: state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule
